// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard sources in, stage-register
// write/flush controls and status/performance counters out.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 16
);
  // hazard sources
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_halt;
  logic             ex_MemRead;
  logic [4:0]       ex_rt;
  logic             mem_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  // stage-register controls and status
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             pipe_enable;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // pipeline side: presents hazard sources, consumes controls
  modport master (
    output id_rs, id_rt, id_uses_rt, id_halt, ex_MemRead, ex_rt,
           mem_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
           pipe_enable, halted, fault, stall_count, flush_count
  );

  // controller side
  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_halt, ex_MemRead, ex_rt,
           mem_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
           pipe_enable, halted, fault, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller for the 5-stage MIPS pipeline.
// Controls are combinational from state and inputs so that a hazard is
// answered in the same cycle it appears; sequencing state is registered.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  pipeline_hazard_controller_if.slave   hz
);

  localparam int WAIT_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int WAIT_W   = (WAIT_RAW > 8) ? WAIT_RAW : 8;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WAIT_W:0]   WAIT_ONE = (WAIT_W + 1)'(1);
  localparam logic [WAIT_W:0]   WAIT_LIM = (WAIT_W + 1)'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_HALTED   = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            r_ret_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [1:0]        r_drain_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_load_use;
  logic              w_memwait;
  logic [WAIT_W:0]   w_wait_inc;
  logic              w_hold_freeze;
  logic              w_enter_freeze;
  logic              w_drain_rules;

  logic              w_pc_write;
  logic              w_if_id_write;
  logic              w_if_id_flush;
  logic              w_id_ex_flush;
  logic              w_ex_mem_flush;
  logic              w_pipe_enable;
  logic              w_halted;
  logic              w_fault;

  state_t            w_nxt_state;
  state_t            w_nxt_ret;
  logic [WAIT_W-1:0] w_nxt_wait;
  logic [1:0]        w_nxt_drain;
  logic              w_stall_inc;
  logic              w_flush_inc;

  // hazard detection and which rule set applies this cycle
  always_comb begin
    w_load_use = hz.ex_MemRead && (hz.ex_rt != 5'd0) &&
                 ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
    w_memwait  = hz.mem_req && !hz.mem_ready;
    w_wait_inc = {1'b0, r_wait_cnt} + WAIT_ONE;
    // while waiting, only mem_ready releases the freeze
    w_hold_freeze  = (r_state == ST_MEM_WAIT) && !hz.mem_ready;
    w_enter_freeze = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && w_memwait;
    // a release from MEM_WAIT resumes whichever sequence it interrupted
    w_drain_rules  = (r_state == ST_DRAIN) ||
                     ((r_state == ST_MEM_WAIT) && (r_ret_state == ST_DRAIN));
  end

  // stage controls and next-state decision
  always_comb begin
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    w_pipe_enable  = 1'b1;
    w_halted       = 1'b0;
    w_fault        = 1'b0;
    w_nxt_state    = r_state;
    w_nxt_ret      = r_ret_state;
    w_nxt_wait     = r_wait_cnt;
    w_nxt_drain    = r_drain_cnt;
    w_stall_inc    = 1'b0;
    w_flush_inc    = 1'b0;

    if (reset) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_pipe_enable = 1'b0;
      w_nxt_state   = ST_RUN;
    end else if ((r_state == ST_HALTED) || (r_state == ST_FAULT)) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_pipe_enable = 1'b0;
      w_halted      = (r_state == ST_HALTED);
      w_fault       = (r_state == ST_FAULT);
    end else if (w_hold_freeze) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_pipe_enable = 1'b0;
      w_stall_inc   = 1'b1;
      w_nxt_wait    = w_wait_inc[WAIT_W-1:0];
      if (w_wait_inc >= WAIT_LIM) begin
        w_nxt_state = ST_FAULT;
      end else begin
        w_nxt_state = ST_MEM_WAIT;
      end
    end else if (w_enter_freeze) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_pipe_enable = 1'b0;
      w_stall_inc   = 1'b1;
      w_nxt_wait    = WAIT_W'(1);
      w_nxt_ret     = (r_state == ST_DRAIN) ? ST_DRAIN : ST_RUN;
      w_nxt_state   = ST_MEM_WAIT;
    end else if (hz.mem_branch_taken) begin
      // taken branch squashes everything younger, including a speculative halt
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
      w_ex_mem_flush = 1'b1;
      w_flush_inc    = 1'b1;
      w_nxt_state    = ST_RUN;
    end else if (w_drain_rules) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
      w_nxt_drain   = r_drain_cnt - 2'd1;
      if (r_drain_cnt <= 2'd1) begin
        w_nxt_state = ST_HALTED;
      end else begin
        w_nxt_state = ST_DRAIN;
      end
    end else if (w_load_use) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
      w_stall_inc   = 1'b1;
      w_nxt_state   = ST_RUN;
    end else if (hz.id_halt) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
      w_nxt_drain   = 2'd2;
      w_nxt_state   = ST_DRAIN;
    end else begin
      w_nxt_state = ST_RUN;
    end
  end

  // sequencing state and saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_ret_state <= ST_RUN;
      r_wait_cnt  <= '0;
      r_drain_cnt <= 2'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_ret_state <= w_nxt_ret;
      r_wait_cnt  <= w_nxt_wait;
      r_drain_cnt <= w_nxt_drain;
      if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign hz.pc_write     = w_pc_write;
  assign hz.if_id_write  = w_if_id_write;
  assign hz.if_id_flush  = w_if_id_flush;
  assign hz.id_ex_flush  = w_id_ex_flush;
  assign hz.ex_mem_flush = w_ex_mem_flush;
  assign hz.pipe_enable  = w_pipe_enable;
  assign hz.halted       = w_halted;
  assign hz.fault        = w_fault;
  assign hz.stall_count  = r_stall_cnt;
  assign hz.flush_count  = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios followed by
// randomized traffic, all checked against a cycle-level reference model.
module tb_pipeline_hazard_controller;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  // reference model: freeze length, drain cycles left, terminal flags
  int m_freeze;
  bit m_ret_drain;
  int m_drain_left;
  bit m_halted;
  bit m_fault;
  int m_stalls;
  int m_flushes;
  bit e_pc, e_ifw, e_iff, e_idf, e_exf, e_pe, e_halt, e_fault;

  pipeline_hazard_controller_if #(.CNT_W(CW)) hz ();

  pipeline_hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b0; hz.id_halt = 1'b0;
    hz.ex_MemRead = 1'b0; hz.ex_rt = 5'd0; hz.mem_branch_taken = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
  endtask

  task automatic model_step();
    bit lu, mw, waiting, draining, frz;
    e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_exf = 0; e_pe = 1; e_halt = 0; e_fault = 0;
    if (reset) begin
      e_pc = 0; e_ifw = 0; e_pe = 0;
      m_freeze = 0; m_ret_drain = 0; m_drain_left = 0;
      m_halted = 0; m_fault = 0; m_stalls = 0; m_flushes = 0;
    end else if (m_fault || m_halted) begin
      e_pc = 0; e_ifw = 0; e_pe = 0;
      e_fault = m_fault; e_halt = m_halted;
    end else begin
      lu = hz.ex_MemRead && (hz.ex_rt != 0) &&
           ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
      mw = hz.mem_req && !hz.mem_ready;
      waiting  = (m_freeze > 0);
      draining = waiting ? m_ret_drain : (m_drain_left > 0);
      frz      = waiting ? !hz.mem_ready : mw;
      if (frz) begin
        e_pc = 0; e_ifw = 0; e_pe = 0;
        if (m_stalls < CMAX) m_stalls++;
        if (waiting) begin
          m_freeze++;
          if (m_freeze >= TO) m_fault = 1;
        end else begin
          m_freeze = 1;
          m_ret_drain = draining;
        end
      end else begin
        m_freeze = 0;
        if (hz.mem_branch_taken) begin
          e_iff = 1; e_idf = 1; e_exf = 1;
          if (m_flushes < CMAX) m_flushes++;
          m_drain_left = 0;
        end else if (draining) begin
          e_pc = 0; e_ifw = 0; e_idf = 1;
          m_drain_left--;
          if (m_drain_left == 0) m_halted = 1;
        end else if (lu) begin
          e_pc = 0; e_ifw = 0; e_idf = 1;
          if (m_stalls < CMAX) m_stalls++;
        end else if (hz.id_halt) begin
          e_pc = 0; e_ifw = 0; e_idf = 1;
          m_drain_left = 2;
        end
      end
    end
  endtask

  // one clock: inputs already driven at the falling edge
  task automatic cyc();
    chk("stall_count", int'(hz.stall_count), m_stalls);
    chk("flush_count", int'(hz.flush_count), m_flushes);
    model_step();
    #1;
    chk("pc_write", hz.pc_write, e_pc);
    chk("if_id_write", hz.if_id_write, e_ifw);
    chk("if_id_flush", hz.if_id_flush, e_iff);
    chk("id_ex_flush", hz.id_ex_flush, e_idf);
    chk("ex_mem_flush", hz.ex_mem_flush, e_exf);
    chk("pipe_enable", hz.pipe_enable, e_pe);
    chk("halted", hz.halted, e_halt);
    chk("fault", hz.fault, e_fault);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    bit pending;
    n_total = 0; n_bad = 0;
    m_freeze = 0; m_ret_drain = 0; m_drain_left = 0;
    m_halted = 0; m_fault = 0; m_stalls = 0; m_flushes = 0;
    pending = 0;
    idle();
    reset = 1'b1;
    @(negedge clk);
    cyc();
    chk("rst_pc_write", hz.pc_write, 0);
    reset = 1'b0;
    chk("rst_stall", int'(hz.stall_count), 0);

    // load-use bubble, then the same with ex_rt == 0
    hz.ex_MemRead = 1'b1; hz.ex_rt = 5'd5; hz.id_rs = 5'd5;
    #1 chk("lu_pc_write", hz.pc_write, 0);
    chk("lu_idex_flush", hz.id_ex_flush, 1);
    cyc();
    chk("lu_stall_cnt", int'(hz.stall_count), 1);
    hz.ex_rt = 5'd0; hz.id_rs = 5'd0;
    cyc();
    chk("lu_r0_stall_cnt", int'(hz.stall_count), 1);
    // rt-source match only counts when the ID instruction reads rt
    hz.ex_rt = 5'd7; hz.id_rt = 5'd7; hz.id_rs = 5'd1;
    cyc();
    hz.id_uses_rt = 1'b1;
    cyc();
    chk("lu_rt_stall_cnt", int'(hz.stall_count), 2);

    // load-use and taken branch together: branch wins
    do_reset();
    hz.ex_MemRead = 1'b1; hz.ex_rt = 5'd5; hz.id_rs = 5'd5; hz.mem_branch_taken = 1'b1;
    cyc();
    chk("br_lu_flush_cnt", int'(hz.flush_count), 1);
    chk("br_lu_stall_cnt", int'(hz.stall_count), 0);

    // three-cycle memory freeze then release
    idle();
    hz.mem_req = 1'b1;
    repeat (3) cyc();
    hz.mem_ready = 1'b1;
    #1 chk("frz_release_pe", hz.pipe_enable, 1);
    cyc();
    idle();
    cyc();
    chk("frz_stall_cnt", int'(hz.stall_count), 3);

    // memory timeout
    do_reset();
    hz.mem_req = 1'b1;
    repeat (3) cyc();
    chk("to_fault_early", hz.fault, 0);
    cyc();
    chk("to_fault", hz.fault, 1);
    hz.mem_ready = 1'b1;
    repeat (2) cyc();
    chk("to_fault_sticky", hz.fault, 1);
    do_reset();
    chk("to_rst_fault", hz.fault, 0);
    chk("to_rst_stall", int'(hz.stall_count), 0);

    // halt drains in three cycles
    hz.id_halt = 1'b1;
    repeat (3) cyc();
    chk("halt_halted", hz.halted, 1);
    repeat (2) cyc();

    // halt cancelled by a taken branch in its second cycle
    do_reset();
    hz.id_halt = 1'b1;
    cyc();
    hz.mem_branch_taken = 1'b1;
    cyc();
    idle();
    repeat (3) cyc();
    chk("halt_br_halted", hz.halted, 0);
    chk("halt_br_flush", int'(hz.flush_count), 1);

    // memory freeze during drain resumes the drain
    do_reset();
    hz.id_halt = 1'b1;
    cyc();
    hz.mem_req = 1'b1;
    repeat (2) cyc();
    hz.mem_ready = 1'b1;
    cyc();
    idle();
    repeat (2) cyc();
    chk("drain_frz_halted", hz.halted, 1);

    // reset in the second cycle of a freeze
    do_reset();
    hz.mem_req = 1'b1;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    idle();
    #1 chk("rst_frz_pc_write", hz.pc_write, 1);
    cyc();
    chk("rst_frz_stall", int'(hz.stall_count), 0);

    // counter saturation
    hz.ex_MemRead = 1'b1; hz.ex_rt = 5'd3; hz.id_rs = 5'd3;
    repeat (20) cyc();
    chk("stall_sat", int'(hz.stall_count), CMAX);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      hz.id_rs        = 5'($urandom_range(0, 3));
      hz.id_rt        = 5'($urandom_range(0, 3));
      hz.ex_rt        = 5'($urandom_range(0, 3));
      hz.id_uses_rt   = ($urandom_range(0, 1) == 0);
      hz.ex_MemRead   = ($urandom_range(0, 2) == 0);
      hz.id_halt      = ($urandom_range(0, 29) == 0);
      hz.mem_branch_taken = ($urandom_range(0, 9) == 0);
      if (!pending) pending = ($urandom_range(0, 7) == 0);
      hz.mem_req   = pending;
      hz.mem_ready = pending && ($urandom_range(0, 2) == 0);
      if (hz.mem_ready) pending = 0;
      if (m_halted || m_fault) reset = ($urandom_range(0, 3) == 0);
      else reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequencing controller for the 5-stage MIPS pipeline: decides each cycle whether PC, IF/ID, ID/EX, EX/MEM and MEM/WB advance, stall or flush. It resolves load-use hazards against the instruction in ID and flushes on a taken branch resolved in MEM. It freezes the whole pipeline while a multi-cycle data-memory access is outstanding and drains the pipeline on a halt instruction. It sits beside ID_Stage and drives the write/flush controls of every stage register; flush of ID/EX zeroes the control bits that ID_Control_Unit would otherwise pass on.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive memory freeze cycles before fault.
- CNT_W, 16: width of performance counters.

- clk  in  1  pipeline clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- id_rs  in  5  instruction[25:21] of instruction in ID.
- id_rt  in  5  instruction[20:16] of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, sw, beq).
- id_halt  in  1  ID instruction is a halt.
- ex_MemRead  in  1  MemRead of instruction in EX.
- ex_rt  in  5  destination rt of instruction in EX.
- mem_branch_taken  in  1  branch in MEM resolved taken.
- mem_req  in  1  data memory access active in MEM.
- mem_ready  in  1  data memory completes access this cycle.
- pc_write  out  1  PC loads next value.
- if_id_write  out  1  IF/ID loads.
- if_id_flush  out  1  IF/ID loads a nop.
- id_ex_flush  out  1  ID/EX loads zeroed controls (bubble).
- ex_mem_flush  out  1  EX/MEM loads zeroed controls.
- pipe_enable  out  1  ID/EX, EX/MEM, MEM/WB load.
- halted  out  1  pipeline drained after halt.
- fault  out  1  memory timeout; sticky until reset.
- stall_count  out  CNT_W  load-use bubbles + memory freeze cycles, saturating.
- flush_count  out  CNT_W  taken-branch flushes, saturating.

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED, FAULT. Registers: state, ret_state (RUN/DRAIN), wait_cnt (8+ bits, sized for MEM_TIMEOUT), drain_cnt (2 bits), counters.
- Outputs are combinational from state and inputs (same-cycle hazard response). Default: pc_write=if_id_write=pipe_enable=1, all flushes 0.
- load_use = ex_MemRead & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- memwait = mem_req & !mem_ready.
- RUN priority, highest first:
  - memwait: freeze (pc_write=if_id_write=pipe_enable=0, no flush); ret_state=RUN, wait_cnt=1, next MEM_WAIT; stall_count+1.
  - mem_branch_taken: if_id_flush=id_ex_flush=ex_mem_flush=1, pc_write=1; flush_count+1.
  - load_use: pc_write=if_id_write=0, id_ex_flush=1; stall_count+1.
  - id_halt: pc_write=if_id_write=0, id_ex_flush=1; drain_cnt=2, next DRAIN.
- MEM_WAIT: mem_ready=0 → freeze, wait_cnt+1, stall_count+1; if wait_cnt==MEM_TIMEOUT → next FAULT. mem_ready=1 → outputs follow ret_state rules with memwait false; next state per those rules (RUN or DRAIN).
- DRAIN: pc_write=if_id_write=0, id_ex_flush=1, pipe_enable=1. memwait → freeze, ret_state=DRAIN, to MEM_WAIT, drain_cnt held. mem_branch_taken → halt was speculative: full branch flush, pc_write=1, flush_count+1, next RUN. Otherwise drain_cnt-1; at drain_cnt==0 next HALTED.
- HALTED: all write/enable 0, flushes 0, halted=1; exits only on reset.
- FAULT: all write/enable 0, flushes 0, fault=1; exits only on reset.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset (synchronous): next state RUN, counters 0, wait_cnt 0, drain_cnt 0. While reset high: pc_write=if_id_write=pipe_enable=0, all flushes 0, halted=0, fault=0.
- Hazard responses are zero-latency (same cycle as inputs); state changes take effect next cycle.
- Load-use bubble lasts exactly 1 cycle; next cycle the load is in MEM and load_use is false.
- Freeze spans every cycle with mem_req=1, mem_ready=0; release is the cycle mem_ready=1.
- Halt: 3 drain cycles (halt cycle + 2 DRAIN), halted=1 on the 4th cycle.
- Reset mid MEM_WAIT/DRAIN/FAULT: abandons sequence; RUN next cycle.

## Test plan
- ex_MemRead=1, ex_rt=5, id_rs=5 for 1 cycle → pc_write=0, if_id_write=0, id_ex_flush=1, stall_count 0→1; repeat with ex_rt=0 → no stall, count unchanged.
- load_use and mem_branch_taken in same cycle → three flushes, pc_write=1, flush_count=1, stall_count=0.
- mem_req=1, mem_ready=0 for 3 cycles then 1 → pipe_enable=0 for 3 cycles, 1 on 4th, stall_count=3, state RUN after.
- MEM_TIMEOUT=4, mem_ready held 0 → fault=1 from 5th cycle, all enables 0, held until reset; after reset fault=0, counters 0.
- id_halt=1 → pc_write=0 for cycles 1-3, halted=1 from cycle 4; rerun with mem_branch_taken=1 in cycle 2 → flush_count=1, RUN, halted stays 0.
- Reset asserted during cycle 2 of a memory freeze → RUN next cycle, pc_write=1 once reset released with no hazards, stall_count=0.
